riscv_pipe_ctrl: RTL and testbench



---
 rtl/riscv_pkg.sv | 13 +
 rtl/riscv_hazard_cmp.sv | 27 ++
 rtl/riscv_pipe_ctrl.sv | 137 +++++++++++++
 tb/tb_riscv_pipe_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: pipeline-control state encoding and
// the register-index width used by ID, the register file and hazard logic.
package riscv_pkg;

  localparam int REGFILE_COUNT = 32;
  localparam int REG_ADDR_W    = $clog2(REGFILE_COUNT);

  typedef enum logic [0:0] {
    PS_RUN     = 1'b0,
    PS_MC_WAIT = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/riscv_hazard_cmp.sv
// Combinational source/destination comparator: flags a load in EX whose rd is
// read by the instruction in ID. Index 0 is hard-wired zero and never matches.
module riscv_hazard_cmp #(
  parameter int RA = 5
) (
  input  logic          id_valid_i,
  input  logic [RA-1:0] id_rs0_i,
  input  logic [RA-1:0] id_rs1_i,
  input  logic          id_uses_rs0_i,
  input  logic          id_uses_rs1_i,
  input  logic          ex_valid_i,
  input  logic          ex_is_load_i,
  input  logic          ex_writes_rd_i,
  input  logic [RA-1:0] ex_rd_i,
  output logic          load_use_o
);

  logic rd_live;
  logic rs0_hit;
  logic rs1_hit;

  assign rd_live    = ex_valid_i & ex_writes_rd_i & (ex_rd_i != '0);
  assign rs0_hit    = id_uses_rs0_i & (id_rs0_i == ex_rd_i);
  assign rs1_hit    = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
  assign load_use_o = id_valid_i & ex_is_load_i & rd_live & (rs0_hit | rs1_hit);

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline control for the 5-stage core: load-use bubbles, branch flushes,
// multi-cycle EX hold tracking, and saturating stall/flush event counters.
module riscv_pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int REGFILE_COUNT = 32,
  parameter int WORD_SIZE     = 32,
  parameter int MC_LATENCY    = 4,
  localparam int RA           = $clog2(REGFILE_COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_valid_i,
  input  logic [RA-1:0]        id_rs0_i,
  input  logic [RA-1:0]        id_rs1_i,
  input  logic                 id_uses_rs0_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_is_load_i,
  input  logic                 ex_writes_rd_i,
  input  logic [RA-1:0]        ex_rd_i,
  input  logic                 ex_mc_start_i,
  input  logic                 ex_branch_taken_i,
  output logic                 stall_if_o,
  output logic                 stall_id_o,
  output logic                 bubble_ex_o,
  output logic                 ex_hold_o,
  output logic                 flush_if_o,
  output logic                 flush_id_o,
  output logic [WORD_SIZE-1:0] stall_cnt_o,
  output logic [WORD_SIZE-1:0] flush_cnt_o
);

  localparam int MCW = $clog2(MC_LATENCY);
  // Start cycle counts as the first EX cycle, so WAIT covers the remaining LATENCY-1.
  localparam logic [MCW-1:0] MC_INIT = MCW'(MC_LATENCY - 2);

  pipe_state_e          state_q, state_d;
  logic [MCW-1:0]       mc_cnt_q, mc_cnt_d;
  logic [WORD_SIZE-1:0] stall_cnt_q, stall_cnt_d;
  logic [WORD_SIZE-1:0] flush_cnt_q, flush_cnt_d;
  logic                 load_use;
  logic                 redirect;

  riscv_hazard_cmp #(
    .RA(RA)
  ) u_hazard_cmp (
    .id_valid_i    (id_valid_i),
    .id_rs0_i      (id_rs0_i),
    .id_rs1_i      (id_rs1_i),
    .id_uses_rs0_i (id_uses_rs0_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .ex_valid_i    (ex_valid_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_writes_rd_i(ex_writes_rd_i),
    .ex_rd_i       (ex_rd_i),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    bubble_ex_o = 1'b0;
    ex_hold_o   = 1'b0;
    flush_if_o  = 1'b0;
    flush_id_o  = 1'b0;
    redirect    = 1'b0;

    if (rst_i) begin
      // Keep wrong-path state out of the pipe while reset is held.
      flush_if_o = 1'b1;
      flush_id_o = 1'b1;
    end else begin
      unique case (state_q)
        PS_RUN: begin
          if (ex_branch_taken_i) begin
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
            redirect   = 1'b1;
          end else if (load_use) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
          end else if (ex_mc_start_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            ex_hold_o  = 1'b1;
            state_d    = PS_MC_WAIT;
            mc_cnt_d   = MC_INIT;
          end
        end
        PS_MC_WAIT: begin
          stall_if_o = 1'b1;
          stall_id_o = 1'b1;
          ex_hold_o  = 1'b1;
          if (mc_cnt_q == '0) begin
            state_d = PS_RUN;
          end else begin
            mc_cnt_d = mc_cnt_q - 1'b1;
          end
        end
        default: state_d = PS_RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_id_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PS_RUN;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl; counters are narrowed to 4 bits so the
// saturation boundary is reachable with a short run of real stall cycles.
module tb_riscv_pipe_ctrl;

  localparam int RA = 5;
  localparam int WS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [RA-1:0] id_rs0, id_rs1;
  logic          id_uses_rs0, id_uses_rs1;
  logic          ex_valid, ex_is_load, ex_writes_rd;
  logic [RA-1:0] ex_rd;
  logic          ex_mc_start, ex_branch_taken;
  logic          stall_if, stall_id, bubble_ex, ex_hold, flush_if, flush_id;
  logic [WS-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  riscv_pipe_ctrl #(
    .REGFILE_COUNT(32),
    .WORD_SIZE    (WS),
    .MC_LATENCY   (4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .id_valid_i       (id_valid),
    .id_rs0_i         (id_rs0),
    .id_rs1_i         (id_rs1),
    .id_uses_rs0_i    (id_uses_rs0),
    .id_uses_rs1_i    (id_uses_rs1),
    .ex_valid_i       (ex_valid),
    .ex_is_load_i     (ex_is_load),
    .ex_writes_rd_i   (ex_writes_rd),
    .ex_rd_i          (ex_rd),
    .ex_mc_start_i    (ex_mc_start),
    .ex_branch_taken_i(ex_branch_taken),
    .stall_if_o       (stall_if),
    .stall_id_o       (stall_id),
    .bubble_ex_o      (bubble_ex),
    .ex_hold_o        (ex_hold),
    .flush_if_o       (flush_if),
    .flush_id_o       (flush_id),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
  );

  always #5 clk = ~clk;

  // Control vector order: {stall_if, stall_id, bubble_ex, ex_hold, flush_if, flush_id}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b111000;
  localparam logic [5:0] C_MC    = 6'b110100;
  localparam logic [5:0] C_FLUSH = 6'b000011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("step %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {26'd0, stall_if, stall_id, bubble_ex, ex_hold, flush_if, flush_id}, {26'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs0 = 0; id_rs1 = 0; id_uses_rs0 = 0; id_uses_rs1 = 0;
    ex_valid = 0; ex_is_load = 0; ex_writes_rd = 0; ex_rd = 0;
    ex_mc_start = 0; ex_branch_taken = 0;
  endtask

  task automatic set_load_use();
    idle();
    ex_valid = 1; ex_is_load = 1; ex_writes_rd = 1; ex_rd = 5'd5;
    id_valid = 1; id_rs1 = 5'd5; id_uses_rs1 = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    // Reset is held: flushes asserted, no stalls
    chk_ctl("rst_ctl", C_FLUSH);
    tick();
    tick();
    rst = 0;
    chk_ctl("rel_ctl", C_NONE);
    chk("rel_stall", 32'(stall_cnt), 32'd0);
    chk("rel_flush", 32'(flush_cnt), 32'd0);
    tick();

    // Load-use on rs1: one bubble cycle
    set_load_use();
    chk_ctl("lu_rs1", C_LU);
    tick();
    ex_valid = 0;
    chk_ctl("lu_after", C_NONE);
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    tick();

    // Load-use through rs0
    idle();
    ex_valid = 1; ex_is_load = 1; ex_writes_rd = 1; ex_rd = 5'd7;
    id_valid = 1; id_rs0 = 5'd7; id_uses_rs0 = 1; id_rs1 = 5'd7; id_uses_rs1 = 0;
    chk_ctl("lu_rs0", C_LU);
    tick();

    // Non-hazards
    set_load_use(); ex_rd = 0; id_rs1 = 0;
    chk_ctl("nh_rd0", C_NONE);
    tick();
    set_load_use(); id_uses_rs1 = 0;
    chk_ctl("nh_nouse", C_NONE);
    tick();
    set_load_use(); id_valid = 0;
    chk_ctl("nh_idinv", C_NONE);
    tick();
    set_load_use(); ex_is_load = 0;
    chk_ctl("nh_noload", C_NONE);
    tick();
    chk("nh_stall", 32'(stall_cnt), 32'd2);

    // Multi-cycle op: 4 held cycles, branch and load-use ignored while waiting
    idle();
    ex_mc_start = 1;
    chk_ctl("mc_start", C_MC);
    tick();
    set_load_use();
    ex_branch_taken = 1;
    chk_ctl("mc_wait1", C_MC);
    tick();
    chk_ctl("mc_wait2", C_MC);
    tick();
    chk_ctl("mc_wait3", C_MC);
    tick();
    idle();
    chk_ctl("mc_done", C_NONE);
    chk("mc_stall", 32'(stall_cnt), 32'd6);
    chk("mc_flush", 32'(flush_cnt), 32'd0);
    tick();

    // Branch beats load-use and a simultaneous mc start
    set_load_use();
    ex_branch_taken = 1;
    ex_mc_start = 1;
    chk_ctl("br_prio", C_FLUSH);
    tick();
    idle();
    chk_ctl("br_after", C_NONE);
    chk("br_flush", 32'(flush_cnt), 32'd1);
    chk("br_stall", 32'(stall_cnt), 32'd6);
    tick();

    // Reset during the second PS_MC_WAIT cycle
    ex_mc_start = 1;
    chk_ctl("rm_start", C_MC);
    tick();
    ex_mc_start = 0;
    chk_ctl("rm_wait1", C_MC);
    tick();
    rst = 1;
    chk_ctl("rm_rst", C_FLUSH);
    tick();
    rst = 0;
    chk_ctl("rm_rel", C_NONE);
    chk("rm_stall", 32'(stall_cnt), 32'd0);
    chk("rm_flush", 32'(flush_cnt), 32'd0);
    tick();

    // Back in PS_RUN: load-use works; drive stall count to saturation
    set_load_use();
    chk_ctl("sat_lu", C_LU);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(stall_cnt), 32'd14);
    chk_ctl("sat_lu2", C_LU);
    tick();
    chk("sat_15", 32'(stall_cnt), 32'd15);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
